mem_port_arbiter: RTL

//  Shares one single-port, 1-cycle-read-latency BRAM between instruction fetch (IF) and data memory (MEM).

---
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port BRAM (1-cycle read latency) between instruction fetch and data memory.
// Data wins contention unless fetch has been starved for MAX_STARVE consecutive cycles.
module mem_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int MAX_STARVE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              flush,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_be,
    input  logic [31:0]       dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic              bram_en,
    output logic [3:0]        bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stall_if,
    output logic              stall_dm
);

    localparam int CNT_W = $clog2(MAX_STARVE + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_PEND = 2'd1,
        DM_RD   = 2'd2,
        DM_WR   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   starve_q, starve_d;
    logic               kill_q, kill_d;
    logic [DATA_W-1:0]  if_rdata_q, dm_rdata_q;
    logic               force_if, grant_if, grant_dm;
    logic               if_ret, dm_rd_ret;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                dm_addr[31:ADDR_W+2], dm_addr[1:0]};

    assign force_if = (starve_q == CNT_W'(MAX_STARVE));
    assign grant_dm = dm_req & ~(if_req & force_if);
    assign grant_if = if_req & ~grant_dm;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            kill_q     <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            kill_q   <= kill_d;
            if (if_ret)
                if_rdata_q <= bram_rdata;
            if (dm_rd_ret)
                dm_rdata_q <= bram_rdata;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (grant_if)
            state_d = IF_PEND;
        else if (grant_dm)
            state_d = dm_we ? DM_WR : DM_RD;
    end

    // Flush during the issue cycle is remembered so the return a cycle later is dropped.
    always_comb begin
        kill_d   = grant_if & flush;
        starve_d = '0;
        if (if_req & ~grant_if)
            starve_d = force_if ? starve_q : starve_q + CNT_W'(1);
    end

    always_comb begin
        bram_en    = 1'b0;
        bram_we    = 4'b0000;
        bram_addr  = '0;
        bram_wdata = '0;
        if (grant_dm) begin
            bram_en    = 1'b1;
            bram_addr  = dm_addr[ADDR_W+1:2];
            bram_we    = dm_we ? dm_be : 4'b0000;
            bram_wdata = dm_wdata;
        end else if (grant_if) begin
            bram_en    = 1'b1;
            bram_addr  = if_addr[ADDR_W+1:2];
            bram_wdata = dm_wdata;
        end
    end

    // Returns are presented in the cycle the BRAM data arrives, then held in the _q registers.
    always_comb begin
        stall_if  = if_req & ~grant_if;
        stall_dm  = dm_req & ~grant_dm;
        if_ret    = (state_q == IF_PEND) & ~kill_q & ~flush;
        dm_rd_ret = (state_q == DM_RD);
        if_valid  = if_ret;
        dm_valid  = (state_q == DM_RD) | (state_q == DM_WR);
        if_rdata  = if_ret    ? bram_rdata : if_rdata_q;
        dm_rdata  = dm_rd_ret ? bram_rdata : dm_rdata_q;
    end

endmodule
